ps2_cmd_ctrl: RTL and testbench

//  Host-to-keyboard command sequencer for the PS/2 keyboard path. Issues reset (FF) and
//  set-LED (ED,xx) commands through the PS/2 transmitter and consumes the keyboard's

---
 rtl/ps2_cmd_ctrl_if.sv | 27 ++
 rtl/ps2_cmd_ctrl.sv | 150 +++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_cmd_ctrl_if.sv
// Signal bundle between the PS/2 command sequencer and its surroundings:
// requests, receiver bytes, transmitter handshake, forwarded keycodes and status.
interface ps2_cmd_ctrl_if;
    logic       init_req;
    logic       led_req;
    logic [2:0] led_state;
    logic       rx_en;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_done;
    logic       key_en;
    logic [7:0] key_data;
    logic       busy;
    logic       cmd_ok;
    logic       cmd_fail;

    modport master (
        input  init_req, led_req, led_state, rx_en, rx_data, tx_done,
        output tx_data, tx_en, key_en, key_data, busy, cmd_ok, cmd_fail
    );

    modport slave (
        output init_req, led_req, led_state, rx_en, rx_data, tx_done,
        input  tx_data, tx_en, key_en, key_data, busy, cmd_ok, cmd_fail
    );
endinterface

// File: rtl/ps2_cmd_ctrl.sv
// Host-to-keyboard command sequencer: sends FF / ED,xx, consumes FA/FE/FC/AA
// replies with timeout and whole-command retry, and forwards all other bytes.
module ps2_cmd_ctrl #(
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 22
) (
    input  logic           clk,
    input  logic           reset,
    ps2_cmd_ctrl_if.master bus
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT, DONE, FAIL
    } state_t;

    state_t           state;
    logic             is_init;
    logic             byte_idx;
    logic             led_pend;
    logic [2:0]       led_val;
    logic [2:0]       pend_val;
    logic [RW-1:0]    retry;
    logic [CNT_W-1:0] cnt;

    logic [7:0] cur_byte;
    logic       consume;
    logic       fail_evt;
    logic       last_byte;

    always_comb begin
        cur_byte  = is_init ? 8'hFF : (byte_idx ? {5'b0, led_val} : 8'hED);
        last_byte = is_init || byte_idx;
        consume   = 1'b0;
        if (bus.rx_en) begin
            if (state == WAIT_ACK)
                consume = (bus.rx_data == 8'hFA) || (bus.rx_data == 8'hFE) ||
                          (bus.rx_data == 8'hFC);
            else if (state == WAIT_BAT)
                consume = (bus.rx_data == 8'hAA) || (bus.rx_data == 8'hFC);
        end
        // A byte in the same cycle as the timeout takes precedence; >= keeps
        // the timeout alive if a non-reply byte masked the exact match.
        fail_evt = 1'b0;
        if (state == WAIT_ACK || state == WAIT_BAT)
            fail_evt = bus.rx_en ? (consume && bus.rx_data == 8'hFC) : (cnt >= CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            is_init      <= 1'b0;
            byte_idx     <= 1'b0;
            led_pend     <= 1'b0;
            led_val      <= '0;
            pend_val     <= '0;
            retry        <= '0;
            cnt          <= '0;
            bus.tx_data  <= '0;
            bus.tx_en    <= 1'b0;
            bus.key_en   <= 1'b0;
            bus.key_data <= '0;
            bus.busy     <= 1'b0;
            bus.cmd_ok   <= 1'b0;
            bus.cmd_fail <= 1'b0;
        end else begin
            bus.tx_en    <= 1'b0;
            bus.cmd_ok   <= 1'b0;
            bus.cmd_fail <= 1'b0;
            bus.key_en   <= bus.rx_en && !consume;
            if (bus.rx_en && !consume)
                bus.key_data <= bus.rx_data;
            if (bus.busy && bus.led_req) begin
                led_pend <= 1'b1;
                pend_val <= bus.led_state;
            end

            case (state)
                IDLE: begin
                    if (bus.init_req || bus.led_req || led_pend) begin
                        is_init  <= bus.init_req;
                        led_val  <= bus.led_req ? bus.led_state : pend_val;
                        byte_idx <= 1'b0;
                        retry    <= '0;
                        led_pend <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    bus.tx_en   <= 1'b1;
                    bus.tx_data <= cur_byte;
                    state       <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.tx_done) begin
                        cnt   <= '0;
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK, WAIT_BAT: begin
                    cnt <= cnt + 1'b1;
                    if (fail_evt) begin
                        if (retry < RETRY_MAX) begin
                            retry    <= retry + 1'b1;
                            byte_idx <= 1'b0;
                            state    <= SEND;
                        end else begin
                            state <= FAIL;
                        end
                    end else if (state == WAIT_BAT) begin
                        if (bus.rx_en && bus.rx_data == 8'hAA)
                            state <= DONE;
                    end else if (bus.rx_en && bus.rx_data == 8'hFA) begin
                        if (!last_byte) begin
                            byte_idx <= 1'b1;
                            state    <= SEND;
                        end else if (is_init) begin
                            cnt   <= '0;
                            state <= WAIT_BAT;
                        end else begin
                            state <= DONE;
                        end
                    end else if (bus.rx_en && bus.rx_data == 8'hFE) begin
                        state <= SEND;
                    end
                end
                DONE: begin
                    bus.cmd_ok <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                FAIL: begin
                    bus.cmd_fail <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Self-checking bench for ps2_cmd_ctrl: a transmitter model answers tx_en with
// tx_done, and queues of expected tx bytes, forwarded bytes and results are scored.
module tb_ps2_cmd_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_cmd_ctrl_if bus ();

    ps2_cmd_ctrl #(.TIMEOUT_CYC(100), .MAX_RETRY(3), .CNT_W(22)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rx_en;
        logic [7:0] rx_data;
        logic       exp_en;
        logic [7:0] exp_data;
    } idle_vec_t;

    typedef struct {
        logic [2:0] leds;
        logic [7:0] exp_byte;
    } led_vec_t;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int res_cnt = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_key[$];
    bit exp_res[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_led(input logic [2:0] s);
        step();
        bus.led_req = 1'b1;
        bus.led_state = s;
        step();
        bus.led_req = 1'b0;
    endtask

    task automatic pulse_init();
        step();
        bus.init_req = 1'b1;
        step();
        bus.init_req = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit fwd);
        if (fwd) exp_key.push_back(b);
        step();
        bus.rx_en = 1'b1;
        bus.rx_data = b;
        step();
        bus.rx_en = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int b;
        b = 0;
        while (done_cnt < target && b < 300) begin
            step();
            b++;
        end
        check("tx_done_reached", done_cnt >= target, 1);
    endtask

    task automatic wait_res(input int target, input int budget);
        int b;
        b = 0;
        while (res_cnt < target && b < budget) begin
            step();
            b++;
        end
        check("result_reached", res_cnt >= target, 1);
    endtask

    // Transmitter model: tx_done three cycles after each tx_en.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_en === 1'b1) begin
                repeat (3) @(negedge clk);
                bus.tx_done = 1'b1;
                done_cnt++;
                @(negedge clk);
                bus.tx_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_en === 1'b1) begin
                check("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) check("tx_data", bus.tx_data, exp_tx.pop_front());
            end
            if (bus.key_en === 1'b1) begin
                check("key_expected", exp_key.size() != 0, 1);
                if (exp_key.size() != 0) check("key_data", bus.key_data, exp_key.pop_front());
            end
            if (bus.cmd_ok === 1'b1 || bus.cmd_fail === 1'b1) begin
                check("res_exclusive", bus.cmd_ok & bus.cmd_fail, 0);
                check("res_expected", exp_res.size() != 0, 1);
                if (exp_res.size() != 0) check("res_kind", bus.cmd_fail, exp_res.pop_front());
                res_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idle_vec_t idle_tab[8];
        led_vec_t  led_tab[4];
        int d;
        int r;

        idle_tab[0] = '{1'b1, 8'h1C, 1'b1, 8'h1C};
        idle_tab[1] = '{1'b1, 8'hFA, 1'b1, 8'hFA};
        idle_tab[2] = '{1'b0, 8'h55, 1'b0, 8'h00};
        idle_tab[3] = '{1'b1, 8'hAA, 1'b1, 8'hAA};
        idle_tab[4] = '{1'b1, 8'hFE, 1'b1, 8'hFE};
        idle_tab[5] = '{1'b1, 8'hFC, 1'b1, 8'hFC};
        idle_tab[6] = '{1'b1, 8'h00, 1'b1, 8'h00};
        idle_tab[7] = '{1'b1, 8'hFF, 1'b1, 8'hFF};
        led_tab[0]  = '{3'b101, 8'h05};
        led_tab[1]  = '{3'b000, 8'h00};
        led_tab[2]  = '{3'b111, 8'h07};
        led_tab[3]  = '{3'b010, 8'h02};

        reset = 1'b1;
        bus.init_req = 1'b0;
        bus.led_req = 1'b0;
        bus.led_state = 3'b000;
        bus.rx_en = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_tx_en", bus.tx_en, 0);
        check("rst_key_en", bus.key_en, 0);
        check("rst_cmd_ok", bus.cmd_ok, 0);
        check("rst_cmd_fail", bus.cmd_fail, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_key_data", bus.key_data, 0);
        step();
        reset = 1'b0;

        // Idle forwarding, latency one cycle, replies included.
        for (int i = 0; i < 8; i++) begin
            step();
            bus.rx_en = idle_tab[i].rx_en;
            bus.rx_data = idle_tab[i].rx_data;
            if (idle_tab[i].rx_en) exp_key.push_back(idle_tab[i].rx_data);
            @(posedge clk);
            #1;
            check("idle_key_en", bus.key_en, idle_tab[i].exp_en);
            if (idle_tab[i].exp_en) check("idle_key_data", bus.key_data, idle_tab[i].exp_data);
        end
        step();
        bus.rx_en = 1'b0;

        // LED commands acknowledged FA, FA.
        for (int i = 0; i < 4; i++) begin
            d = done_cnt;
            r = res_cnt;
            exp_tx.push_back(8'hED);
            exp_tx.push_back(led_tab[i].exp_byte);
            exp_res.push_back(1'b0);
            pulse_led(led_tab[i].leds);
            check("busy_after_req", bus.busy, 1);
            wait_done(d + 1);
            send_rx(8'hFA, 1'b0);
            wait_done(d + 2);
            send_rx(8'hFA, 1'b0);
            wait_res(r + 1, 50);
            check("busy_after_done", bus.busy, 0);
        end

        // Init: idle byte first, then FF / FA / AA.
        send_rx(8'h1C, 1'b1);
        d = done_cnt;
        r = res_cnt;
        exp_tx.push_back(8'hFF);
        exp_res.push_back(1'b0);
        pulse_init();
        wait_done(d + 1);
        send_rx(8'hFA, 1'b0);
        send_rx(8'hAA, 1'b0);
        wait_res(r + 1, 50);

        // Init with FC during BAT wait retries the whole command.
        d = done_cnt;
        r = res_cnt;
        exp_tx.push_back(8'hFF);
        exp_tx.push_back(8'hFF);
        exp_res.push_back(1'b0);
        pulse_init();
        wait_done(d + 1);
        send_rx(8'hFA, 1'b0);
        send_rx(8'hFC, 1'b0);
        wait_done(d + 2);
        send_rx(8'hFA, 1'b0);
        send_rx(8'hAA, 1'b0);
        wait_res(r + 1, 50);

        // FE resend; FA before tx_done and a non-reply byte are forwarded.
        d = done_cnt;
        r = res_cnt;
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h03);
        exp_res.push_back(1'b0);
        pulse_led(3'b011);
        send_rx(8'hFA, 1'b1);
        wait_done(d + 1);
        send_rx(8'h1C, 1'b1);
        send_rx(8'hFE, 1'b0);
        wait_done(d + 2);
        send_rx(8'hFA, 1'b0);
        wait_done(d + 3);
        send_rx(8'hFA, 1'b0);
        wait_res(r + 1, 50);

        // FC after ED restarts the command.
        d = done_cnt;
        r = res_cnt;
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h06);
        exp_res.push_back(1'b0);
        pulse_led(3'b110);
        wait_done(d + 1);
        send_rx(8'hFC, 1'b0);
        wait_done(d + 2);
        send_rx(8'hFA, 1'b0);
        wait_done(d + 3);
        send_rx(8'hFA, 1'b0);
        wait_res(r + 1, 50);

        // Requests while busy: last pending LED state wins.
        d = done_cnt;
        r = res_cnt;
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h04);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h02);
        exp_res.push_back(1'b0);
        exp_res.push_back(1'b0);
        pulse_led(3'b100);
        pulse_led(3'b111);
        pulse_led(3'b010);
        wait_done(d + 1);
        send_rx(8'hFA, 1'b0);
        wait_done(d + 2);
        send_rx(8'hFA, 1'b0);
        wait_done(d + 3);
        send_rx(8'hFA, 1'b0);
        wait_done(d + 4);
        send_rx(8'hFA, 1'b0);
        wait_res(r + 2, 100);

        // No replies: 1+MAX_RETRY transmissions then cmd_fail.
        r = res_cnt;
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'hED);
        exp_res.push_back(1'b1);
        pulse_led(3'b001);
        wait_res(r + 1, 1000);
        repeat (20) step();
        check("timeout_tx_count", exp_tx.size(), 0);

        // Reset in WAIT_ACK abandons silently; following FA is forwarded.
        d = done_cnt;
        r = res_cnt;
        exp_tx.push_back(8'hED);
        pulse_led(3'b111);
        wait_done(d + 1);
        step();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_cmd_ok", bus.cmd_ok, 0);
        check("mid_rst_cmd_fail", bus.cmd_fail, 0);
        step();
        reset = 1'b0;
        send_rx(8'hFA, 1'b1);
        repeat (150) step();
        check("mid_rst_no_result", res_cnt, r);

        check("tx_queue_empty", exp_tx.size(), 0);
        check("key_queue_empty", exp_key.size(), 0);
        check("res_queue_empty", exp_res.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
